// File: rtl/stage_reader.sv
// Read side of an FFT stage buffer: claims a FULL buffer, walks the radix-2 DIT
// butterfly address pairs for one stage and streams them out. Twiddle indices: STAGE_READER_TWIDDLE_EN.
module stage_reader #(
    parameter int N         = 8,
    parameter int LOG_N     = 3,
    parameter int LOG_LOG_N = 2,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LOG_LOG_N-1:0] stage_idx,
    input  logic [1:0]           buf_state,
    output logic [LOG_N-1:0]     buf_addr0,
    output logic [LOG_N-1:0]     buf_addr1,
    input  logic [WIDTH-1:0]     buf_data0,
    input  logic [WIDTH-1:0]     buf_data1,
    output logic                 buf_active,
    output logic                 out_nd,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [LOG_N-1:0]     out_addr0,
    output logic [LOG_N-1:0]     out_addr1,
    output logic [LOG_N-2:0]     out_tw_addr,
    output logic                 out_last,
    output logic                 error,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LOG_N-2:0]   K_LAST   = (LOG_N-1)'(N/2 - 1);
    localparam logic [LOG_N-1:0]   ONE      = LOG_N'(1);
    localparam logic [LOG_LOG_N:0] STAGES   = (LOG_LOG_N+1)'(LOG_N);
    localparam logic [1:0]         ST_FULL  = 2'd2;

    state_t                 state_q, state_d;
    logic [LOG_N-2:0]       k_q, k_d;
    logic [LOG_LOG_N-1:0]   s_q, s_d;
    logic                   active_q, active_d;
    logic                   nd_q, nd_d;
    logic                   last_q, last_d;
    logic                   err_q, err_d;
    logic [WIDTH-1:0]       data0_q, data0_d;
    logic [WIDTH-1:0]       data1_q, data1_d;
    logic [LOG_N-1:0]       addr0_q, addr0_d;
    logic [LOG_N-1:0]       addr1_q, addr1_d;

    logic [LOG_N-1:0]       k_ext;
    logic [LOG_N-1:0]       mask;
    logic [LOG_N-1:0]       stride;
    logic [LOG_N-1:0]       rd_addr0;
    logic [LOG_N-1:0]       rd_addr1;
    logic                   advance;
    logic                   stage_bad;

    // Pair k of stage s: insert a zero at bit s of k for the lower address,
    // the partner sits 2^s above it.
    always_comb begin
        k_ext    = {1'b0, k_q};
        mask     = ~({LOG_N{1'b1}} << s_q);
        stride   = ONE << s_q;
        rd_addr0 = (((k_ext >> s_q) << s_q) << 1) | (k_ext & mask);
        rd_addr1 = rd_addr0 + stride;
    end

`ifdef STAGE_READER_TWIDDLE_EN
    logic [LOG_N-2:0]     tw_q, tw_d;
    logic [LOG_N-2:0]     rd_tw;
    logic [LOG_LOG_N-1:0] tw_shift;

    always_comb begin
        tw_shift = LOG_LOG_N'(LOG_N-1) - s_q;
        rd_tw    = (k_q & mask[LOG_N-2:0]) << tw_shift;
    end

    assign out_tw_addr = tw_q;
`else
    assign out_tw_addr = '0;
`endif

    // Output handshake: a pair transfers on a rising edge where out_nd and
    // out_ready are both high; while out_nd & ~out_ready every output holds.
    assign advance   = ~nd_q | out_ready;
    assign stage_bad = {1'b0, stage_idx} >= STAGES;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        s_d      = s_q;
        active_d = active_q;
        nd_d     = nd_q;
        last_d   = last_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        addr0_d  = addr0_q;
        addr1_d  = addr1_q;
`ifdef STAGE_READER_TWIDDLE_EN
        tw_d     = tw_q;
`endif
        err_d    = err_q | (active_q & ~buf_state[1]);

        case (state_q)
            IDLE: begin
                if (buf_state == ST_FULL) begin
                    if (stage_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        active_d = 1'b1;
                        k_d      = '0;
                        s_d      = stage_idx;
                    end
                end
            end
            READ: begin
                if (advance) begin
                    data0_d = buf_data0;
                    data1_d = buf_data1;
                    addr0_d = rd_addr0;
                    addr1_d = rd_addr1;
`ifdef STAGE_READER_TWIDDLE_EN
                    tw_d    = rd_tw;
`endif
                    nd_d    = 1'b1;
                    k_d     = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        last_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    nd_d    = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            s_q      <= '0;
            active_q <= 1'b0;
            nd_q     <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
`ifdef STAGE_READER_TWIDDLE_EN
            tw_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            active_q <= active_d;
            nd_q     <= nd_d;
            last_q   <= last_d;
            err_q    <= err_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
`ifdef STAGE_READER_TWIDDLE_EN
            tw_q     <= tw_d;
`endif
        end
    end

    assign buf_addr0  = (state_q == READ) ? rd_addr0 : '0;
    assign buf_addr1  = (state_q == READ) ? rd_addr1 : '0;
    assign buf_active = active_q;
    assign out_nd     = nd_q;
    assign out_data0  = data0_q;
    assign out_data1  = data1_q;
    assign out_addr0  = addr0_q;
    assign out_addr1  = addr1_q;
    assign out_last   = last_q;
    assign error      = err_q;
    assign dbg_state  = state_q;

endmodule
